// File: rtl/reg_pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// reg_pipeline_ctrl_if
//   Bundle of the control/payload signals of the multi-stage pipeline
//   register (reg_pipeline_ctrl). Clock and reset stay plain module ports.
//
//   Parameters
//     TAM          payload width in bits
//     PROFUNDIDADE number of register stages (width of the flush mask)
//
//   Signals
//     parada        global stall (driven by master)
//     limpar        per-stage flush mask, bit k = stage k (driven by master)
//     valido_in     payload at 'in' is a real instruction (driven by master)
//     in            payload into stage 0 (driven by master)
//     out           payload of the last stage (driven by slave)
//     valido_out    valid bit of the last stage (driven by slave)
//     ocupacao      number of valid stages (driven by slave)
//     cont_paradas  stall-cycle counter (driven by slave)
//     cont_limpez   flush-event counter (driven by slave)
//
//   Modports
//     master  upstream controller / testbench side
//     slave   pipeline register side
// ---------------------------------------------------------------------------
interface reg_pipeline_ctrl_if #(
  parameter int TAM          = 32,
  parameter int PROFUNDIDADE = 1
);

  localparam int OCC_W = $clog2(PROFUNDIDADE + 1);

  logic                    parada;
  logic [PROFUNDIDADE-1:0] limpar;
  logic                    valido_in;
  logic [TAM-1:0]          in;
  logic [TAM-1:0]          out;
  logic                    valido_out;
  logic [OCC_W-1:0]        ocupacao;
  logic [31:0]             cont_paradas;
  logic [31:0]             cont_limpez;

  modport master (
    output parada,
    output limpar,
    output valido_in,
    output in,
    input  out,
    input  valido_out,
    input  ocupacao,
    input  cont_paradas,
    input  cont_limpez
  );

  modport slave (
    input  parada,
    input  limpar,
    input  valido_in,
    input  in,
    output out,
    output valido_out,
    output ocupacao,
    output cont_paradas,
    output cont_limpez
  );

endinterface

// File: rtl/reg_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// reg_pipeline_ctrl
//   Parametrised multi-stage pipeline register for the MIPS32 datapath.
//   Carries a TAM-bit payload plus a valid bit through PROFUNDIDADE stages,
//   with a global stall (parada), a per-stage flush mask (limpar) and an
//   occupancy count (ocupacao). One instance replaces the single-stage
//   IF/ID, ID/EX, EX/MEM and MEM/WB registers and can also cover
//   multi-cycle stages.
//
//   Parameters
//     TAM          payload width in bits (1..256)
//     PROFUNDIDADE number of register stages (1..8)
//     VALOR_LIMPO  payload value loaded on reset and on flush
//
//   Ports
//     clock   system clock, all state updates on the rising edge
//     reset   asynchronous, active-high reset
//     bus     reg_pipeline_ctrl_if.slave:
//               parada, limpar, valido_in, in      (inputs)
//               out, valido_out, ocupacao,
//               cont_paradas, cont_limpez          (outputs)
//
//   Optional feature
//     REG_PIPELINE_CONTADORES_EN  when defined, cont_paradas counts edges
//     with parada=1 and cont_limpez counts edges with any limpar bit set;
//     both saturate at 32'hFFFFFFFF. When undefined, no counter flops
//     exist and both outputs are tied to zero.
// ---------------------------------------------------------------------------
module reg_pipeline_ctrl #(
  parameter int             TAM          = 32,
  parameter int             PROFUNDIDADE = 1,
  parameter logic [TAM-1:0] VALOR_LIMPO  = '0
) (
  input logic               clock,
  input logic               reset,
  reg_pipeline_ctrl_if.slave bus
);

  localparam int OCC_W = $clog2(PROFUNDIDADE + 1);

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // Number of set bits in the valid vector.
  function automatic logic [OCC_W-1:0] popcount(input logic [PROFUNDIDADE-1:0] v);
    int n;
    n = 0;
    for (int k = 0; k < PROFUNDIDADE; k++) begin
      if (v[k]) begin
        n = n + 1;
      end
    end
    return OCC_W'(n);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    if (c == 32'hFFFF_FFFF) begin
      return c;
    end
    return c + 32'd1;
  endfunction

  // -------------------------------------------------------------------------
  // Stage state
  // -------------------------------------------------------------------------
  logic [TAM-1:0]          data_p   [PROFUNDIDADE];
  logic [PROFUNDIDADE-1:0] vld_p;
  logic [OCC_W-1:0]        occ_p;

  // Upstream source of every stage: stage 0 is fed from the port, stage k
  // from the pre-edge content of stage k-1, so a flush of stage k-1 in the
  // same cycle never leaks into stage k.
  logic [TAM-1:0]          src_data [PROFUNDIDADE];
  logic [PROFUNDIDADE-1:0] src_vld;

  logic [TAM-1:0]          data_nxt [PROFUNDIDADE];
  logic [PROFUNDIDADE-1:0] vld_nxt;

  always_comb begin
    src_data[0] = bus.in;
    src_vld[0]  = bus.valido_in;
    for (int k = 1; k < PROFUNDIDADE; k++) begin
      src_data[k] = data_p[k-1];
      src_vld[k]  = vld_p[k-1];
    end
  end

  // Per-stage priority: flush, then stall (hold), then advance.
  always_comb begin
    data_nxt = data_p;
    vld_nxt  = vld_p;
    for (int k = 0; k < PROFUNDIDADE; k++) begin
      if (bus.limpar[k]) begin
        data_nxt[k] = VALOR_LIMPO;
        vld_nxt[k]  = 1'b0;
      end else if (!bus.parada) begin
        data_nxt[k] = src_data[k];
        vld_nxt[k]  = src_vld[k];
      end
    end
  end

  // ---- stage boundary: all PROFUNDIDADE register stages ----
  // Occupancy is registered from the next-state valid vector so the output
  // comes straight from flops and matches the valid bits after every edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < PROFUNDIDADE; k++) begin
        data_p[k] <= VALOR_LIMPO;
      end
      vld_p <= '0;
      occ_p <= '0;
    end else begin
      for (int k = 0; k < PROFUNDIDADE; k++) begin
        data_p[k] <= data_nxt[k];
      end
      vld_p <= vld_nxt;
      occ_p <= popcount(vld_nxt);
    end
  end

  assign bus.out        = data_p[PROFUNDIDADE-1];
  assign bus.valido_out = vld_p[PROFUNDIDADE-1];
  assign bus.ocupacao   = occ_p;

  // -------------------------------------------------------------------------
  // Event counters
  // -------------------------------------------------------------------------
`ifdef REG_PIPELINE_CONTADORES_EN
  logic [31:0] cnt_stall_p;
  logic [31:0] cnt_flush_p;

  // A flush counts once per edge, whatever the number of bits set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_stall_p <= '0;
      cnt_flush_p <= '0;
    end else begin
      if (bus.parada) begin
        cnt_stall_p <= sat_inc(cnt_stall_p);
      end
      if (|bus.limpar) begin
        cnt_flush_p <= sat_inc(cnt_flush_p);
      end
    end
  end

  assign bus.cont_paradas = cnt_stall_p;
  assign bus.cont_limpez  = cnt_flush_p;
`else
  assign bus.cont_paradas = 32'd0;
  assign bus.cont_limpez  = 32'd0;
`endif

endmodule

// File: tb/tb_reg_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_pipeline_ctrl
//   Self-checking bench for reg_pipeline_ctrl. Two instances run side by
//   side on the same stimulus: a 2-stage, clean-value-0 pipe and a 1-stage
//   pipe whose clean value is 32'hDEADBEEF (it sees limpar[0] only).
//   The reference model keeps the stage contents as plain arrays updated
//   from the behavioural rules (flush beats stall, stall holds, otherwise
//   shift by one using pre-edge values).
// ---------------------------------------------------------------------------
module tb_reg_pipeline_ctrl;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  reg_pipeline_ctrl_if #(.TAM(32), .PROFUNDIDADE(2)) b2 ();
  reg_pipeline_ctrl_if #(.TAM(32), .PROFUNDIDADE(1)) b1 ();

  reg_pipeline_ctrl #(
    .TAM(32), .PROFUNDIDADE(2), .VALOR_LIMPO(32'h0000_0000)
  ) dut2 (
    .clock(clock), .reset(reset), .bus(b2)
  );

  reg_pipeline_ctrl #(
    .TAM(32), .PROFUNDIDADE(1), .VALOR_LIMPO(32'hDEAD_BEEF)
  ) dut1 (
    .clock(clock), .reset(reset), .bus(b1)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] md [2];
  logic        mv [2];
  logic [31:0] m1d;
  logic        m1v;
  logic [31:0] mpar;
  logic [31:0] mlim;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    md[0] = 32'h0; md[1] = 32'h0;
    mv[0] = 1'b0;  mv[1] = 1'b0;
    m1d   = 32'hDEAD_BEEF;
    m1v   = 1'b0;
    mpar  = 32'd0;
    mlim  = 32'd0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic [31:0] old_d0;
    logic        old_v0;
    old_d0 = md[0];
    old_v0 = mv[0];
    if (b2.limpar[0]) begin
      md[0] = 32'h0; mv[0] = 1'b0;
    end else if (!b2.parada) begin
      md[0] = b2.in; mv[0] = b2.valido_in;
    end
    if (b2.limpar[1]) begin
      md[1] = 32'h0; mv[1] = 1'b0;
    end else if (!b2.parada) begin
      md[1] = old_d0; mv[1] = old_v0;
    end
    if (b1.limpar[0]) begin
      m1d = 32'hDEAD_BEEF; m1v = 1'b0;
    end else if (!b1.parada) begin
      m1d = b1.in; m1v = b1.valido_in;
    end
    if (b2.parada && mpar != 32'hFFFF_FFFF) mpar = mpar + 32'd1;
    if ((b2.limpar != 2'b00) && mlim != 32'hFFFF_FFFF) mlim = mlim + 32'd1;
  endtask

  task automatic check_all(input string tag);
    logic [1:0]  exp_occ;
    logic [31:0] exp_par;
    logic [31:0] exp_lim;
    exp_occ = 2'(mv[0]) + 2'(mv[1]);
`ifdef REG_PIPELINE_CONTADORES_EN
    exp_par = mpar;
    exp_lim = mlim;
`else
    exp_par = 32'd0;
    exp_lim = 32'd0;
`endif
    check({tag, "_out"},   64'(b2.out),          64'(md[1]));
    check({tag, "_vout"},  64'(b2.valido_out),   64'(mv[1]));
    check({tag, "_occ"},   64'(b2.ocupacao),     64'(exp_occ));
    check({tag, "_cpar"},  64'(b2.cont_paradas), 64'(exp_par));
    check({tag, "_clim"},  64'(b2.cont_limpez),  64'(exp_lim));
    check({tag, "_out1"},  64'(b1.out),          64'(m1d));
    check({tag, "_vout1"}, 64'(b1.valido_out),   64'(m1v));
  endtask

  // Drive inputs, take one edge, update the model, check #1 after the edge.
  task automatic cycle(input logic par, input logic [1:0] lim, input logic vin,
                       input logic [31:0] din, input string tag);
    b2.parada    = par;
    b2.limpar    = lim;
    b2.valido_in = vin;
    b2.in        = din;
    b1.parada    = par;
    b1.limpar    = lim[0];
    b1.valido_in = vin;
    b1.in        = din;
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    b2.parada = 1'b0; b2.limpar = 2'b00; b2.valido_in = 1'b0; b2.in = 32'h0;
    b1.parada = 1'b0; b1.limpar = 1'b0;  b1.valido_in = 1'b0; b1.in = 32'h0;
    model_reset();

    // Reset state, visible before any clock edge
    reset = 1'b1;
    #2;
    check_all("rst");
    @(posedge clock);
    #1;
    check_all("rst_hold");
    @(negedge clock);
    reset = 1'b0;

    // Streaming fill: 0x11 out after edge 2, 0x22 after 3, 0x33 after 4
    cycle(1'b0, 2'b00, 1'b1, 32'h11, "s1_e1");
    cycle(1'b0, 2'b00, 1'b1, 32'h22, "s1_e2");
    check("s1_out_11", 64'(b2.out), 64'h11);
    check("s1_occ_2", 64'(b2.ocupacao), 64'd2);
    cycle(1'b0, 2'b00, 1'b1, 32'h33, "s1_e3");
    check("s1_out_22", 64'(b2.out), 64'h22);
    cycle(1'b0, 2'b00, 1'b0, 32'h0, "s1_e4");
    check("s1_out_33", 64'(b2.out), 64'h33);
    check("s1_vout", 64'(b2.valido_out), 64'd1);

    // Stall holds every stage for three edges
    cycle(1'b0, 2'b00, 1'b1, 32'h44, "s2_load");
    cycle(1'b1, 2'b00, 1'b1, 32'hAA, "s2_st1");
    cycle(1'b1, 2'b00, 1'b1, 32'hBB, "s2_st2");
    cycle(1'b1, 2'b00, 1'b1, 32'hCC, "s2_st3");
    cycle(1'b0, 2'b00, 1'b1, 32'h55, "s2_go");
    check("s2_out_44", 64'(b2.out), 64'h44);

    // Flush stage 0 while stalled: bubble in place, stage 1 holds
    cycle(1'b0, 2'b00, 1'b1, 32'h66, "s3_fill");
    cycle(1'b1, 2'b01, 1'b1, 32'h77, "s3_fl");
    check("s3_occ_1", 64'(b2.ocupacao), 64'd1);
    check("s3_out1_clean", 64'(b1.out), 64'hDEAD_BEEF);
    check("s3_vout1", 64'(b1.valido_out), 64'd0);

    // Flush whole pipe, then next word needs two edges
    cycle(1'b0, 2'b00, 1'b1, 32'h88, "s4_f1");
    cycle(1'b0, 2'b00, 1'b1, 32'h99, "s4_f2");
    cycle(1'b0, 2'b11, 1'b1, 32'hA5, "s4_fl");
    check("s4_out_0", 64'(b2.out), 64'h0);
    check("s4_occ_0", 64'(b2.ocupacao), 64'd0);
    cycle(1'b0, 2'b00, 1'b1, 32'hB6, "s4_n1");
    cycle(1'b0, 2'b00, 1'b1, 32'hC7, "s4_n2");
    check("s4_out_b6", 64'(b2.out), 64'hB6);

    // Asynchronous reset between edges while streaming
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("s5_async");
    @(negedge clock);
    reset = 1'b0;
    cycle(1'b0, 2'b00, 1'b1, 32'h11, "s5_r1");
    cycle(1'b0, 2'b00, 1'b1, 32'h22, "s5_r2");
    check("s5_out_11", 64'(b2.out), 64'h11);

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 400; i++) begin
      logic        par;
      logic [1:0]  lim;
      par = ($urandom_range(0, 3) == 0);
      lim = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cycle(par, lim, 1'($urandom), $urandom, "rnd");
      if ($urandom_range(0, 49) == 0) begin
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("rnd_rst");
        @(negedge clock);
        reset = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the directed sequence is bounded, this only guards against a hang
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
